// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB-Lite master arbiter: address/control are muxed by the address-phase owner and HWDATA by the data-phase owner.
// Latency: the grant registers at an hready edge, the new master's address follows one hready cycle later, and its data one after that.
// Backpressure: with hready=0 the grant, both owners and the beat counter hold; HRESP is observed only.
//
// Ports:
//   hclk, hreset          bus clock, asynchronous active-high reset
//   m_hbusreq / m_hgrant  per-master request in, one-hot grant out
//   m_h*                  packed per-master AHB address/control/write data (master i at slice i)
//   hready, hresp         shared slave-side response
//   s_h*                  muxed AHB address/control (address owner) and HWDATA (data owner)
//   s_hmaster             address-phase owner index
//   lock_timeout_err      sticky lock-watchdog flag
//
// Optional build macro AHB_ARB_LOCK_TIMEOUT_EN: when defined, a watchdog counts cycles in which a
// locked owner blocks another requester and raises lock_timeout_err at LOCK_TIMEOUT; otherwise the flag is 0.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int DEFAULT_MASTER = 0,
    parameter int LOCK_TIMEOUT   = 64
) (
    input  logic                       hclk,
    input  logic                       hreset,
    input  logic [NUM_MASTERS-1:0]     m_hbusreq,
    output logic [NUM_MASTERS-1:0]     m_hgrant,
    input  logic [NUM_MASTERS*32-1:0]  m_haddr,
    input  logic [NUM_MASTERS*2-1:0]   m_htrans,
    input  logic [NUM_MASTERS-1:0]     m_hwrite,
    input  logic [NUM_MASTERS*3-1:0]   m_hsize,
    input  logic [NUM_MASTERS*3-1:0]   m_hburst,
    input  logic [NUM_MASTERS*4-1:0]   m_hprot,
    input  logic [NUM_MASTERS-1:0]     m_hmastlock,
    input  logic [NUM_MASTERS*32-1:0]  m_hwdata,
    input  logic                       hready,
    input  logic                       hresp,
    output logic [31:0]                s_haddr,
    output logic [1:0]                 s_htrans,
    output logic                       s_hwrite,
    output logic [2:0]                 s_hsize,
    output logic [2:0]                 s_hburst,
    output logic [3:0]                 s_hprot,
    output logic                       s_hmastlock,
    output logic [31:0]                s_hwdata,
    output logic [1:0]                 s_hmaster,
    output logic                       lock_timeout_err
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0]             DEF_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] GRANT_RST = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS ||
        LOCK_TIMEOUT < 8 || LOCK_TIMEOUT > 1023) begin : g_param_check
        $error("ahb_master_arbiter: parameter out of range");
    end

    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] grant_next;
    logic [1:0]             addr_owner_q;
    logic [1:0]             data_owner_q;
    logic [1:0]             rr_last;
    logic [3:0]             beat_cnt;
    logic [3:0]             cnt_next;
    logic [1:0]             grant_idx;
    logic [1:0]             lo_idx;
    logic [1:0]             hi_idx;
    logic [1:0]             rr_win;
    logic [1:0]             arb_idx;
    logic                   rr_found;
    logic                   rr_found_hi;
    logic                   hold;

    // HRESP never influences arbitration; the master answers an ERROR with IDLE.
    logic unused_hresp;
    assign unused_hresp = hresp;

    assign m_hgrant  = grant_q;
    assign s_hmaster = addr_owner_q;

    always_comb begin
        grant_idx = DEF_IDX;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) grant_idx = 2'(i);
        end
    end

    // Address/control follow the address-phase owner, write data the data-phase owner.
    always_comb begin
        s_haddr     = m_haddr[31:0];
        s_htrans    = m_htrans[1:0];
        s_hwrite    = m_hwrite[0];
        s_hsize     = m_hsize[2:0];
        s_hburst    = m_hburst[2:0];
        s_hprot     = m_hprot[3:0];
        s_hmastlock = m_hmastlock[0];
        s_hwdata    = m_hwdata[31:0];
        for (int i = 1; i < NUM_MASTERS; i++) begin
            if (addr_owner_q == 2'(i)) begin
                s_haddr     = m_haddr[32*i +: 32];
                s_htrans    = m_htrans[2*i +: 2];
                s_hwrite    = m_hwrite[i];
                s_hsize     = m_hsize[3*i +: 3];
                s_hburst    = m_hburst[3*i +: 3];
                s_hprot     = m_hprot[4*i +: 4];
                s_hmastlock = m_hmastlock[i];
            end
            if (data_owner_q == 2'(i)) s_hwdata = m_hwdata[32*i +: 32];
        end
    end

    // Beats remaining after the current address phase; non-zero keeps the owner granted.
    always_comb begin
        cnt_next = beat_cnt;
        if (hready) begin
            case (s_htrans)
                HTRANS_NONSEQ: begin
                    case (s_hburst)
                        3'd2, 3'd3: cnt_next = 4'd3;
                        3'd4, 3'd5: cnt_next = 4'd7;
                        3'd6, 3'd7: cnt_next = 4'd15;
                        default:    cnt_next = 4'd0;
                    endcase
                end
                HTRANS_SEQ:  cnt_next = (beat_cnt != 4'd0) ? beat_cnt - 4'd1 : 4'd0;
                HTRANS_BUSY: cnt_next = beat_cnt;
                default:     cnt_next = 4'd0;
            endcase
        end
    end

    assign hold = s_hmastlock | (cnt_next != 4'd0);

    // Round robin: the lowest requester above rr_last wins, else wrap to the lowest requester overall.
    always_comb begin
        rr_found    = 1'b0;
        rr_found_hi = 1'b0;
        lo_idx      = DEF_IDX;
        hi_idx      = DEF_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_hbusreq[i]) begin
                rr_found = 1'b1;
                lo_idx   = 2'(i);
                if (2'(i) > rr_last) begin
                    rr_found_hi = 1'b1;
                    hi_idx      = 2'(i);
                end
            end
        end
        rr_win = rr_found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        arb_idx = hold ? addr_owner_q : (rr_found ? rr_win : DEF_IDX);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_next[i] = (arb_idx == 2'(i));
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            grant_q      <= GRANT_RST;
            addr_owner_q <= DEF_IDX;
            data_owner_q <= DEF_IDX;
            rr_last      <= DEF_IDX;
            beat_cnt     <= 4'd0;
        end else if (hready) begin
            grant_q      <= grant_next;
            addr_owner_q <= grant_idx;
            data_owner_q <= addr_owner_q;
            beat_cnt     <= cnt_next;
            // Parking on the default master does not move the round-robin pointer.
            if (!hold && rr_found) rr_last <= rr_win;
        end
    end

`ifdef AHB_ARB_LOCK_TIMEOUT_EN
    logic [9:0]             lock_cnt;
    logic [NUM_MASTERS-1:0] own_mask;
    logic                   lock_blocking;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            own_mask[i] = (addr_owner_q == 2'(i));
        end
    end

    assign lock_blocking = s_hmastlock & (|(m_hbusreq & ~own_mask));

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            lock_cnt         <= 10'd0;
            lock_timeout_err <= 1'b0;
        end else if (lock_blocking) begin
            if (lock_cnt != 10'h3FF) lock_cnt <= lock_cnt + 10'd1;
            if (({1'b0, lock_cnt} + 11'd1) >= 11'(LOCK_TIMEOUT)) lock_timeout_err <= 1'b1;
        end else begin
            lock_cnt <= 10'd0;
        end
    end
`else
    assign lock_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Randomised and directed stimulus for ahb_master_arbiter, scored against a cycle-level reference model.
// Outputs are sampled 1ns after the falling edge; the model advances at each rising edge.
// Directed cases: reset park, round robin, INCR4 handover, stalled WRAP8, lock hold, reset mid INCR16.
module tb_ahb_master_arbiter;
    localparam int N   = 2;
    localparam int DEF = 0;
    localparam int LTO = 64;

    logic              hclk;
    logic              hreset;
    logic [N-1:0]      m_hbusreq;
    logic [N-1:0]      m_hgrant;
    logic [N*32-1:0]   m_haddr;
    logic [N*2-1:0]    m_htrans;
    logic [N-1:0]      m_hwrite;
    logic [N*3-1:0]    m_hsize;
    logic [N*3-1:0]    m_hburst;
    logic [N*4-1:0]    m_hprot;
    logic [N-1:0]      m_hmastlock;
    logic [N*32-1:0]   m_hwdata;
    logic              hready;
    logic              hresp;
    logic [31:0]       s_haddr;
    logic [1:0]        s_htrans;
    logic              s_hwrite;
    logic [2:0]        s_hsize;
    logic [2:0]        s_hburst;
    logic [3:0]        s_hprot;
    logic              s_hmastlock;
    logic [31:0]       s_hwdata;
    logic [1:0]        s_hmaster;
    logic              lock_timeout_err;

    // Per-master stimulus, packed onto the DUT vectors below.
    logic        req_a [N];
    logic [1:0]  tr_a  [N];
    logic        wr_a  [N];
    logic [2:0]  sz_a  [N];
    logic [2:0]  hb_a  [N];
    logic [3:0]  pr_a  [N];
    logic        lk_a  [N];
    logic [31:0] ad_a  [N];
    logic [31:0] wd_a  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_hbusreq[i]        = req_a[i];
            m_htrans[2*i +: 2]  = tr_a[i];
            m_hwrite[i]         = wr_a[i];
            m_hsize[3*i +: 3]   = sz_a[i];
            m_hburst[3*i +: 3]  = hb_a[i];
            m_hprot[4*i +: 4]   = pr_a[i];
            m_hmastlock[i]      = lk_a[i];
            m_haddr[32*i +: 32] = ad_a[i];
            m_hwdata[32*i +: 32] = wd_a[i];
        end
    end

    ahb_master_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .LOCK_TIMEOUT(LTO)) dut (
        .hclk(hclk), .hreset(hreset),
        .m_hbusreq(m_hbusreq), .m_hgrant(m_hgrant),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hprot(m_hprot), .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
        .hready(hready), .hresp(hresp),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hmastlock(s_hmastlock), .s_hwdata(s_hwdata),
        .s_hmaster(s_hmaster), .lock_timeout_err(lock_timeout_err)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: granted master, address owner, data owner, beats left, last RR winner.
    int m_g, m_ao, m_do, m_bc, m_rr;
    bit m_err;
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
    int m_lk;
`endif

    task automatic model_reset();
        m_g = DEF; m_ao = DEF; m_do = DEF; m_bc = 0; m_rr = DEF; m_err = 0;
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
        m_lk = 0;
`endif
    endtask

    // Beats in a fixed-length burst, minus the one being issued now (INCR/SINGLE have none pending).
    function automatic int beats_left(input logic [2:0] hb);
        if (hb < 3'd2) return 0;
        return (4 << ((int'(hb) - 2) / 2)) - 1;
    endfunction

    task automatic model_clock();
        int  nbc, ng, c;
        bit  found, lockd;
        lockd = lk_a[m_ao];
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
        begin
            bit other;
            other = 0;
            for (int j = 0; j < N; j++) if (j != m_ao && req_a[j]) other = 1;
            if (lockd && other) begin
                m_lk++;
                if (m_lk >= LTO) m_err = 1;
            end else begin
                m_lk = 0;
            end
        end
`endif
        if (hready) begin
            case (tr_a[m_ao])
                2'b10:   nbc = beats_left(hb_a[m_ao]);
                2'b11:   nbc = (m_bc > 0) ? m_bc - 1 : 0;
                2'b01:   nbc = m_bc;
                default: nbc = 0;
            endcase
            if (lockd || nbc != 0) begin
                ng = m_ao;
            end else begin
                ng = DEF;
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_rr + k) % N;
                    if (!found && req_a[c]) begin
                        found = 1;
                        ng = c;
                    end
                end
                if (found) m_rr = ng;
            end
            m_do = m_ao;
            m_ao = m_g;
            m_g  = ng;
            m_bc = nbc;
        end
    endtask

    task automatic check_outputs();
        int exp_ctrl;
        exp_ctrl = (int'(tr_a[m_ao]) << 12) | (int'(wr_a[m_ao]) << 11) | (int'(sz_a[m_ao]) << 8) |
                   (int'(hb_a[m_ao]) << 5) | (int'(pr_a[m_ao]) << 1) | int'(lk_a[m_ao]);
        chk("grant",    64'(m_hgrant),  64'(1 << m_g));
        chk("hmaster",  64'(s_hmaster), 64'(m_ao));
        chk("haddr",    64'(s_haddr),   64'(ad_a[m_ao]));
        chk("ctrl",     64'({s_htrans, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock}), 64'(exp_ctrl));
        chk("hwdata",   64'(s_hwdata),  64'(wd_a[m_do]));
        chk("beat_cnt", 64'(dut.beat_cnt), 64'(m_bc));
        chk("lock_err", 64'(lock_timeout_err), 64'(m_err));
    endtask

    task automatic sample();
        #1;
        check_outputs();
    endtask

    task automatic advance();
        @(posedge hclk);
        if (hreset) model_reset();
        else model_clock();
        @(negedge hclk);
    endtask

    task automatic set_m(input int i, input bit req, input logic [1:0] tr, input logic [2:0] hb,
                         input logic [31:0] a, input bit lk);
        req_a[i] = req; tr_a[i] = tr; hb_a[i] = hb; ad_a[i] = a; lk_a[i] = lk;
        wr_a[i] = 1'($urandom); sz_a[i] = 3'd2; pr_a[i] = 4'($urandom); wd_a[i] = $urandom;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) set_m(i, 0, 2'b00, 3'd0, $urandom, 0);
    endtask

    task automatic sync_reset();
        idle_all();
        hready = 1'b1;
        hreset = 1'b1;
        advance();
        advance();
        hreset = 1'b0;
    endtask

    int  acc;
    logic [31:0] last_a;
    logic [31:0] a;

    initial begin
        hready = 1'b1;
        hresp  = 1'b0;
        hreset = 1'b1;
        idle_all();
        model_reset();
        repeat (3) @(negedge hclk);
        hreset = 1'b0;

        // Reset park with no requests.
        for (int c = 0; c < 3; c++) begin
            idle_all();
            sample();
            chk("rst_grant", 64'(m_hgrant), 64'(2'b01));
            chk("rst_hmaster", 64'(s_hmaster), 64'(0));
            chk("rst_haddr", 64'(s_haddr), 64'(m_haddr[31:0]));
            advance();
        end

        // Both masters request with SINGLE NONSEQ: grant alternates every transfer.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_m(i, 1, 2'b10, 3'd0, $urandom, 0);
            sample();
            chk("rr_alt", 64'(m_hgrant), (c % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            advance();
        end

        // M0 INCR4 at 0x1000 while M1 requests.
        sync_reset();
        for (int b = 0; b < 4; b++) begin
            set_m(0, 1, (b == 0) ? 2'b10 : 2'b11, 3'd3, 32'h1000 + 32'(4 * b), 0);
            set_m(1, 1, 2'b00, 3'd0, 32'h8000_0000, 0);
            sample();
            chk("incr4_held", 64'(m_hgrant), 64'(2'b01));
            advance();
        end
        set_m(0, 0, 2'b00, 3'd0, 32'h0, 0);
        set_m(1, 1, 2'b00, 3'd0, 32'h8000_0000, 0);
        sample();
        chk("incr4_grant", 64'(m_hgrant), 64'(2'b10));
        chk("incr4_owner_old", 64'(s_hmaster), 64'(0));
        advance();
        set_m(0, 0, 2'b00, 3'd0, 32'h0, 0);
        set_m(1, 1, 2'b10, 3'd0, 32'h8000_0000, 0);
        sample();
        chk("incr4_owner_new", 64'(s_hmaster), 64'(1));
        chk("incr4_m1_addr", 64'(s_haddr), 64'(32'h8000_0000));
        advance();

        // M0 WRAP8 at 0x2010 with a three-cycle wait state on its third beat.
        sync_reset();
        acc = 0;
        last_a = 32'h0;
        for (int b = 0; b < 8; b++) begin
            a = 32'h2000 + ((32'h10 + 32'(4 * b)) & 32'h1F);
            set_m(0, 1, (b == 0) ? 2'b10 : 2'b11, 3'd4, a, 0);
            set_m(1, 1, 2'b00, 3'd0, $urandom, 0);
            if (b == 2) begin
                for (int w = 0; w < 3; w++) begin
                    hready = 1'b0;
                    sample();
                    chk("wrap8_stall_cnt", 64'(dut.beat_cnt), 64'(6));
                    chk("wrap8_stall_grant", 64'(m_hgrant), 64'(2'b01));
                    advance();
                end
            end
            hready = 1'b1;
            sample();
            if (s_hmaster == 2'd0 && s_htrans != 2'b00) begin
                acc++;
                last_a = s_haddr;
            end
            advance();
        end
        chk("wrap8_beats", 64'(acc), 64'(8));
        chk("wrap8_last", 64'(last_a), 64'(32'h200C));

        // M1 takes the bus, then holds HMASTLOCK for 100 cycles while M0 requests.
        sync_reset();
        for (int c = 0; c < 2; c++) begin
            set_m(0, 0, 2'b00, 3'd0, $urandom, 0);
            set_m(1, 1, 2'b00, 3'd0, $urandom, 0);
            sample();
            advance();
        end
        for (int k = 0; k < 100; k++) begin
            set_m(0, 1, 2'b00, 3'd0, $urandom, 0);
            set_m(1, 1, 2'b10, 3'd0, $urandom, 1);
            sample();
            chk("lock_grant", 64'(m_hgrant), 64'(2'b10));
`ifdef AHB_ARB_LOCK_TIMEOUT_EN
            chk("lock_err_t", 64'(lock_timeout_err), 64'(k >= LTO));
`else
            chk("lock_err_t", 64'(lock_timeout_err), 64'(0));
`endif
            advance();
        end

        // M1 runs INCR16 at 0x4000; reset pulses during its sixth beat.
        for (int b = 0; b < 5; b++) begin
            set_m(0, 1, 2'b00, 3'd0, $urandom, 0);
            set_m(1, 1, (b == 0) ? 2'b10 : 2'b11, 3'd7, 32'h4000 + 32'(4 * b), 0);
            sample();
            chk("incr16_grant", 64'(m_hgrant), 64'(2'b10));
            advance();
        end
        set_m(1, 1, 2'b11, 3'd7, 32'h4014, 0);
        sample();
        #1;
        hreset = 1'b1;
        #1;
        chk("arst_grant", 64'(m_hgrant), 64'(2'b01));
        chk("arst_cnt", 64'(dut.beat_cnt), 64'(0));
        chk("arst_hmaster", 64'(s_hmaster), 64'(0));
        chk("arst_err", 64'(lock_timeout_err), 64'(0));
        model_reset();
        advance();
        hreset = 1'b0;

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                req_a[i] = 1'($urandom);
                tr_a[i]  = 2'($urandom);
                wr_a[i]  = 1'($urandom);
                sz_a[i]  = 3'($urandom);
                hb_a[i]  = 3'($urandom);
                pr_a[i]  = 4'($urandom);
                lk_a[i]  = ($urandom_range(15) == 0);
                ad_a[i]  = $urandom;
                wd_a[i]  = $urandom;
            end
            hready = ($urandom_range(9) != 0);
            hresp  = 1'($urandom);
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ahb_master_arbiter.md
Name: ahb_master_arbiter

Overview:
- Shares one AHB-Lite slave-side bus among NUM_MASTERS request/grant masters. Typical use: core plus a DMA or UVM master agent in front of one slave port.
- Arbitrates round-robin and multiplexes each master's address/control and write data onto the shared bus.
- Tracks address-phase and data-phase ownership separately.
- Keeps a master's grant for the whole of a fixed-length burst, and for as long as it holds HMASTLOCK.

Parameters:
- NUM_MASTERS, 2, number of masters (2..4).
- DEFAULT_MASTER, 0, master that is granted and parked on after reset and when no master requests.
- LOCK_TIMEOUT, 64, cycle limit for the optional lock watchdog (8..1023).

Ports:
- hclk  in  1  bus clock
- hreset  in  1  asynchronous, active-high reset
- m_hbusreq  in  NUM_MASTERS  per-master bus request
- m_hgrant  out  NUM_MASTERS  one-hot grant
- m_haddr  in  NUM_MASTERS*32  packed address, master i at [32i+31:32i]
- m_htrans  in  NUM_MASTERS*2  packed HTRANS
- m_hwrite  in  NUM_MASTERS  HWRITE
- m_hsize  in  NUM_MASTERS*3  HSIZE
- m_hburst  in  NUM_MASTERS*3  HBURST
- m_hprot  in  NUM_MASTERS*4  HPROT
- m_hmastlock  in  NUM_MASTERS  HMASTLOCK
- m_hwdata  in  NUM_MASTERS*32  HWDATA
- hready  in  1  shared HREADY from slave side
- hresp  in  1  shared HRESP (observed only)
- s_haddr  out  32  muxed address
- s_htrans  out  2  muxed HTRANS
- s_hwrite  out  1  muxed HWRITE
- s_hsize  out  3  muxed HSIZE
- s_hburst  out  3  muxed HBURST
- s_hprot  out  4  muxed HPROT
- s_hmastlock  out  1  muxed HMASTLOCK
- s_hwdata  out  32  write data, selected by data-phase owner
- s_hmaster  out  2  address-phase owner index
- lock_timeout_err  out  1  sticky lock-watchdog flag (optional feature)

Behaviour:
- Registers:
  - grant_q: one-hot; drives m_hgrant.
  - addr_owner_q: updates to the index of grant_q when hready=1.
  - data_owner_q: updates to addr_owner_q when hready=1.
  - beat_cnt: 4 bits.
  - rr_last: last granted index.
- Reset values:
  - grant_q = one-hot DEFAULT_MASTER.
  - Both owners = DEFAULT_MASTER; rr_last = DEFAULT_MASTER.
  - beat_cnt = 0; lock_timeout_err = 0.
  - All s_* outputs follow the mux from the reset owner, so they reflect DEFAULT_MASTER's inputs.
- Muxing:
  - s_haddr/htrans/hwrite/hsize/hburst/hprot/hmastlock select addr_owner_q. This path is combinational, zero latency.
  - s_hwdata selects data_owner_q.
  - s_hmaster = addr_owner_q.
- Beat counter. Evaluated on the owner's address phase, and only when hready=1:
  - NONSEQ with INCR4/WRAP4: load 3.
  - NONSEQ with INCR8/WRAP8: load 7.
  - NONSEQ with INCR16/WRAP16: load 15.
  - NONSEQ with SINGLE/INCR: load 0.
  - SEQ: decrement; saturates at 0.
  - BUSY: hold.
  - IDLE: clear to 0 (early termination).
- hold = s_hmastlock | (cnt_next != 0), where cnt_next is the value beat_cnt takes at this edge.
- Arbitration (grant_q updates only when hready=1):
  - hold=1: grant_q stays on addr_owner_q.
  - Otherwise: round-robin search of m_hbusreq starting at rr_last+1 mod NUM_MASTERS. The first requester wins, and rr_last updates to the winner.
  - If only the current owner requests, it keeps the grant.
  - No requests: grant DEFAULT_MASTER (park).
- hready=0: grant_q, both owners and beat_cnt all hold.
- Handover latency:
  - Grant visible on m_hgrant in cycle N (N is a cycle ending with hready=1).
  - New master's address on s_* from cycle N+1.
  - Its data on s_hwdata one hready-qualified cycle later.
- Undefined-length INCR bursts may be preempted at any beat boundary.
- hresp=1 does not change arbitration; the master drives IDLE on the ERROR response, which clears the counter.
- A request at an index ≥ NUM_MASTERS cannot exist. Unused s_hmaster bits are 0.
- hreset asserted mid-burst: all registers return to their reset values immediately (asynchronous reset).

Optional Feature:
- Macro: AHB_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - A 10-bit counter increments each cycle where s_hmastlock=1 and another master's m_hbusreq=1.
  - The counter clears when either condition drops.
  - When the count reaches LOCK_TIMEOUT, lock_timeout_err sets to 1 and stays set until hreset.
  - Arbitration is unaffected.
- Undefined: no counter is built; lock_timeout_err is tied to 0.

Test Plan:
- Reset, no requests → m_hgrant=2'b01, s_hmaster=0, s_haddr=m_haddr[31:0].
- Both masters request continuously and issue SINGLE NONSEQ with hready=1 → grant alternates 01,10,01,… each transfer; s_hwdata follows the owner one cycle behind s_haddr.
- M0 runs an INCR4 at 0x1000 while M1 requests → M1 is not granted until the cycle the 4th beat (0x100C) address is accepted; M1's address appears the next cycle.
- M0 runs a WRAP8 with hready=0 for 3 cycles on beat 2 → grant, owners and beat count frozen; burst completes with all 8 beats on s_*.
- M1 holds m_hmastlock=1 for 100 cycles while M0 requests → grant stays with M1. With AHB_ARB_LOCK_TIMEOUT_EN, lock_timeout_err rises after 64 cycles; without the macro it stays 0.
- hreset pulses mid INCR16 on beat 5 → m_hgrant=01, beat count 0 and owners 0 at once; arbitration restarts cleanly after release.
